// File: rtl/simd_mac_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : simd_mac_accumulator
// Brief    : Pipelined SIMD multiply-accumulate. Operand words split into
//            1, 2 or 4 lanes. Per-lane products accumulate into guarded lane
//            slots over a first..last framed sequence of beats. Results leave
//            through a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module simd_mac_accumulator #(
    parameter int WIDTH   = 16,
    parameter int GUARD   = 8,
    parameter int SAT     = 1,
    parameter int COUNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       a_sign,
    input  logic                       b_sign,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_first,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH+4*GUARD-1:0] out_data,
    output logic [COUNT_W-1:0]         out_count,
    output logic [3:0]                 out_ovf
);

    localparam int C_DW = 2*WIDTH + 4*GUARD;  // packed slot vector width
    localparam int C_PW = 2*WIDTH;            // packed product vector width

    // Handshake
    logic               w_stall;
    logic               w_accept;

    // Mode/sign capture
    logic [1:0]         w_in_mode;
    logic               w_in_a_sign;
    logic               w_in_b_sign;
    logic [1:0]         r_cap_mode;
    logic               r_cap_a_sign;
    logic               r_cap_b_sign;

    // Stage 1
    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic [1:0]         r_s1_mode;
    logic               r_s1_a_sign;
    logic               r_s1_b_sign;
    logic               r_s1_first;
    logic               r_s1_last;

    // Stage 2
    logic               r_s2_valid;
    logic [C_PW-1:0]    r_s2_prod;
    logic [1:0]         r_s2_mode;
    logic               r_s2_psigned;
    logic               r_s2_first;
    logic               r_s2_last;

    // Stage 3 accumulator state
    logic [C_DW-1:0]    r_acc;
    logic [3:0]         r_ovf;
    logic [COUNT_W-1:0] r_count;
    logic               r_open;

    // Per-mode datapath results and their selected versions
    logic [C_PW-1:0]    w_prod_m [3];
    logic [C_DW-1:0]    w_acc_m  [3];
    logic [3:0]         w_ovf_m  [3];
    logic [C_PW-1:0]    w_prod_sel;
    logic [C_DW-1:0]    w_acc_sel;
    logic [3:0]         w_ovf_sel;
    logic               w_fresh;
    logic [COUNT_W-1:0] w_count_nxt;

    // A pending result that downstream refuses freezes the whole pipe.
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_accept = in_valid & in_ready;

    // Mode/signs come live from a first beat, otherwise from the last first beat.
    always_comb begin
        w_in_mode   = r_cap_mode;
        w_in_a_sign = r_cap_a_sign;
        w_in_b_sign = r_cap_b_sign;
        if (in_first) begin
            w_in_mode   = (mode == 2'd3) ? 2'd0 : mode;
            w_in_a_sign = a_sign;
            w_in_b_sign = b_sign;
        end
    end

    // Remember mode/signs of the most recent accepted first beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap_mode   <= 2'd0;
            r_cap_a_sign <= 1'b0;
            r_cap_b_sign <= 1'b0;
        end else if (w_accept && in_first) begin
            r_cap_mode   <= w_in_mode;
            r_cap_a_sign <= w_in_a_sign;
            r_cap_b_sign <= w_in_b_sign;
        end
    end

    // Stage 1: register the accepted beat with its effective mode/signs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_mode   <= 2'd0;
            r_s1_a_sign <= 1'b0;
            r_s1_b_sign <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a      <= a;
                r_s1_b      <= b;
                r_s1_mode   <= w_in_mode;
                r_s1_a_sign <= w_in_a_sign;
                r_s1_b_sign <= w_in_b_sign;
                r_s1_first  <= in_first;
                r_s1_last   <= in_last;
            end
        end
    end

    assign w_fresh = r_s2_first | ~r_open;

    // One datapath per lane configuration; the beat's mode selects the result.
    for (genvar m = 0; m < 3; m++) begin : g_mode
        localparam int LANES = 1 << m;
        localparam int L     = WIDTH >> m;
        localparam int SW    = 2*L + GUARD;

        logic [C_PW-1:0] w_prod;
        logic [C_DW-1:0] w_acc;
        logic [3:0]      w_ovf;

        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [2*L-1:0] w_ax;
            logic [2*L-1:0] w_bx;
            logic [2*L-1:0] w_p;
            logic           w_sx;
            logic [SW-1:0]  w_ext;
            logic [SW-1:0]  w_base;
            logic [SW:0]    w_sum;
            logic           w_lane_ovf;
            logic [SW-1:0]  w_res;

            // Operands widened to 2L bits; the low 2L product bits are exact
            // for any signed/unsigned mix.
            assign w_ax = {{L{r_s1_a_sign & r_s1_a[i*L+L-1]}}, r_s1_a[i*L +: L]};
            assign w_bx = {{L{r_s1_b_sign & r_s1_b[i*L+L-1]}}, r_s1_b[i*L +: L]};
            assign w_p  = w_ax * w_bx;
            assign w_prod[i*2*L +: 2*L] = w_p;

            // Product is signed whenever either operand is signed.
            assign w_sx   = r_s2_psigned & r_s2_prod[i*2*L+2*L-1];
            assign w_ext  = {{GUARD{w_sx}}, r_s2_prod[i*2*L +: 2*L]};
            assign w_base = w_fresh ? '0 : r_acc[i*SW +: SW];
            assign w_sum  = {r_s2_psigned & w_base[SW-1], w_base}
                          + {r_s2_psigned & w_ext[SW-1],  w_ext};

            assign w_lane_ovf = r_s2_psigned ? (w_sum[SW] ^ w_sum[SW-1]) : w_sum[SW];
            assign w_res = (w_lane_ovf && (SAT != 0))
                         ? (r_s2_psigned ? {w_sum[SW], {(SW-1){~w_sum[SW]}}} : {SW{1'b1}})
                         : w_sum[SW-1:0];

            assign w_acc[i*SW +: SW] = w_res;
            assign w_ovf[i] = w_lane_ovf | (~w_fresh & r_ovf[i]);
        end

        if (LANES*SW < C_DW) begin : g_acc_pad
            assign w_acc[C_DW-1:LANES*SW] = '0;
        end
        if (LANES < 4) begin : g_ovf_pad
            assign w_ovf[3:LANES] = '0;
        end

        assign w_prod_m[m] = w_prod;
        assign w_acc_m[m]  = w_acc;
        assign w_ovf_m[m]  = w_ovf;
    end

    // Pick the product vector for the stage-1 beat's lane configuration.
    always_comb begin
        w_prod_sel = w_prod_m[0];
        case (r_s1_mode)
            2'd1:    w_prod_sel = w_prod_m[1];
            2'd2:    w_prod_sel = w_prod_m[2];
            default: w_prod_sel = w_prod_m[0];
        endcase
    end

    // Pick the accumulation result for the stage-2 beat's lane configuration.
    always_comb begin
        w_acc_sel = w_acc_m[0];
        w_ovf_sel = w_ovf_m[0];
        case (r_s2_mode)
            2'd1: begin
                w_acc_sel = w_acc_m[1];
                w_ovf_sel = w_ovf_m[1];
            end
            2'd2: begin
                w_acc_sel = w_acc_m[2];
                w_ovf_sel = w_ovf_m[2];
            end
            default: begin
                w_acc_sel = w_acc_m[0];
                w_ovf_sel = w_ovf_m[0];
            end
        endcase
    end

    assign w_count_nxt = w_fresh ? COUNT_W'(1)
                       : ((&r_count) ? r_count : r_count + COUNT_W'(1));

    // Stage 2: register products plus the control that travels with them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid   <= 1'b0;
            r_s2_prod    <= '0;
            r_s2_mode    <= 2'd0;
            r_s2_psigned <= 1'b0;
            r_s2_first   <= 1'b0;
            r_s2_last    <= 1'b0;
        end else if (!w_stall) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_prod    <= w_prod_sel;
                r_s2_mode    <= r_s1_mode;
                r_s2_psigned <= r_s1_a_sign | r_s1_b_sign;
                r_s2_first   <= r_s1_first;
                r_s2_last    <= r_s1_last;
            end
        end
    end

    // Stage 3: accumulate, and publish the result on a last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            r_ovf     <= 4'd0;
            r_count   <= '0;
            r_open    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 4'd0;
        end else if (!w_stall) begin
            // Not stalled means any held result is being taken this cycle.
            out_valid <= r_s2_valid & r_s2_last;
            if (r_s2_valid) begin
                r_acc   <= w_acc_sel;
                r_ovf   <= w_ovf_sel;
                r_count <= w_count_nxt;
                r_open  <= ~r_s2_last;
                if (r_s2_last) begin
                    out_data  <= w_acc_sel;
                    out_count <= w_count_nxt;
                    out_ovf   <= w_ovf_sel;
                end
            end
        end
    end

endmodule
`default_nettype wire
